// File: rtl/bcd_serial_addsub_pkg.sv
// Shared definitions for the serial BCD adder/subtractor.
//   state_t    : controller states (IDLE, ADD, NEG, DONE)
//   BCD_NINE   : largest legal BCD digit, also the nine's-complement base
//   BCD_SIX    : decimal-correction offset applied when a binary digit sum exceeds 9
//   nines_comp : nine's complement of one BCD digit
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_NEG  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [3:0] BCD_NINE = 4'd9;
    localparam logic [3:0] BCD_SIX  = 4'd6;

    function automatic logic [3:0] nines_comp(input logic [3:0] d);
        return BCD_NINE - d;
    endfunction

endpackage

// File: rtl/bcd_serial_addsub_if.sv
// Operation request / result bundle for bcd_serial_addsub.
//   start, mode, cin, A, B : request side (driven by the master)
//   ready, done, S, cout, neg, err : status and result (driven by the slave)
// A, B and S are packed BCD with the least significant digit at bits [3:0].
interface bcd_serial_addsub_if #(
    parameter int DIGIT_NUM = 8
);
    logic                   start;
    logic                   mode;
    logic                   cin;
    logic [4*DIGIT_NUM-1:0] A;
    logic [4*DIGIT_NUM-1:0] B;
    logic                   ready;
    logic                   done;
    logic [4*DIGIT_NUM-1:0] S;
    logic                   cout;
    logic                   neg;
    logic                   err;

    modport master (
        output start, mode, cin, A, B,
        input  ready, done, S, cout, neg, err
    );

    modport slave (
        input  start, mode, cin, A, B,
        output ready, done, S, cout, neg, err
    );
endinterface

// File: rtl/bcd_digit_adder.sv
// Combinational single-digit BCD adder.
//   a, b : BCD digits (0..9)
//   cin  : incoming decimal carry
//   s    : decimal-corrected sum digit
//   cout : outgoing decimal carry
module bcd_digit_adder
    import bcd_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] bin_sum;

    always_comb begin
        bin_sum = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        if (bin_sum > {1'b0, BCD_NINE}) begin
            // Adding 6 skips the six unused codes; bit 4 of the result is the carry.
            s    = bin_sum[3:0] + BCD_SIX;
            cout = 1'b1;
        end else begin
            s    = bin_sum[3:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD adder/subtractor, one digit per clock, LSD first.
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : request/result bundle (slave side), see bcd_serial_addsub_if
// Subtraction adds the ten's complement of B; a missing final carry means A < B,
// and a second pass (NEG) ten's-complements the stored result to give the magnitude.
module bcd_serial_addsub
    import bcd_pkg::*;
#(
    parameter int DIGIT_NUM = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    bcd_serial_addsub_if.slave   bus
);

    localparam int W     = 4 * DIGIT_NUM;
    localparam int CNT_W = $clog2(DIGIT_NUM + 1);
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(DIGIT_NUM - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [W-1:0]     a_sh_reg, a_sh_next;
    logic [W-1:0]     b_sh_reg, b_sh_next;
    logic [W-1:0]     s_sh_reg, s_sh_next;
    logic             carry_reg, carry_next;
    logic             mode_reg, mode_next;
    logic             cout_reg, cout_next;
    logic             neg_reg, neg_next;
    logic             err_reg, err_next;

    logic [3:0]       add_a, add_b, add_s;
    logic             add_cout;
    logic [W-1:0]     s_shifted;
    logic [DIGIT_NUM-1:0] bad_digit;

    // Per-digit legality check of both incoming operands.
    generate
        for (genvar gi = 0; gi < DIGIT_NUM; gi++) begin : g_digit_chk
            assign bad_digit[gi] = (bus.A[4*gi +: 4] > BCD_NINE) ||
                                   (bus.B[4*gi +: 4] > BCD_NINE);
        end
    endgenerate

    // The single digit adder is shared: in ADD it sees a_i and b_i (or 9-b_i),
    // in NEG it sees 9-d_i plus the running carry.
    always_comb begin
        if (state_reg == ST_NEG) begin
            add_a = nines_comp(s_sh_reg[3:0]);
            add_b = 4'd0;
        end else begin
            add_a = a_sh_reg[3:0];
            add_b = mode_reg ? nines_comp(b_sh_reg[3:0]) : b_sh_reg[3:0];
        end
    end

    bcd_digit_adder u_digit_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_reg),
        .s    (add_s),
        .cout (add_cout)
    );

    // New digits enter at the top so that after DIGIT_NUM shifts the first
    // (least significant) digit has arrived at bits [3:0].
    assign s_shifted = (s_sh_reg >> 4) | (W'(add_s) << (W - 4));

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        a_sh_next  = a_sh_reg;
        b_sh_next  = b_sh_reg;
        s_sh_next  = s_sh_reg;
        carry_next = carry_reg;
        mode_next  = mode_reg;
        cout_next  = cout_reg;
        neg_next   = neg_reg;
        err_next   = err_reg;

        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    cnt_next  = '0;
                    s_sh_next = '0;
                    cout_next = 1'b0;
                    neg_next  = 1'b0;
                    mode_next = bus.mode;
                    if (|bad_digit) begin
                        err_next   = 1'b1;
                        a_sh_next  = '0;
                        b_sh_next  = '0;
                        carry_next = 1'b0;
                        state_next = ST_DONE;
                    end else begin
                        err_next   = 1'b0;
                        a_sh_next  = bus.A;
                        b_sh_next  = bus.B;
                        // The +1 of the ten's complement rides in on the first carry.
                        carry_next = bus.mode ? 1'b1 : bus.cin;
                        state_next = ST_ADD;
                    end
                end
            end

            ST_ADD: begin
                a_sh_next  = a_sh_reg >> 4;
                b_sh_next  = b_sh_reg >> 4;
                s_sh_next  = s_shifted;
                carry_next = add_cout;
                if (cnt_reg == LAST_DIGIT) begin
                    cnt_next = '0;
                    if (!mode_reg) begin
                        cout_next  = add_cout;
                        state_next = ST_DONE;
                    end else if (add_cout) begin
                        // A >= B: the complement sum already is the magnitude.
                        state_next = ST_DONE;
                    end else begin
                        carry_next = 1'b1;
                        state_next = ST_NEG;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            ST_NEG: begin
                s_sh_next  = s_shifted;
                carry_next = add_cout;
                if (cnt_reg == LAST_DIGIT) begin
                    cnt_next   = '0;
                    neg_next   = 1'b1;
                    state_next = ST_DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            s_sh_reg  <= '0;
            carry_reg <= 1'b0;
            mode_reg  <= 1'b0;
            cout_reg  <= 1'b0;
            neg_reg   <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            a_sh_reg  <= a_sh_next;
            b_sh_reg  <= b_sh_next;
            s_sh_reg  <= s_sh_next;
            carry_reg <= carry_next;
            mode_reg  <= mode_next;
            cout_reg  <= cout_next;
            neg_reg   <= neg_next;
            err_reg   <= err_next;
        end
    end

    assign bus.ready = (state_reg == ST_IDLE);
    assign bus.done  = (state_reg == ST_DONE);
    assign bus.S     = s_sh_reg;
    assign bus.cout  = cout_reg;
    assign bus.neg   = neg_reg;
    assign bus.err   = err_reg;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Self-checking bench for bcd_serial_addsub with DIGIT_NUM = 4.
// A decimal-arithmetic model predicts every cycle's ready/done and the results;
// directed vectors carry hand-computed literal results and latencies.
module tb_bcd_serial_addsub;

    localparam int N = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    bcd_serial_addsub_if #(.DIGIT_NUM(N)) bus ();

    bcd_serial_addsub #(.DIGIT_NUM(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors     = 0;
    int checks     = 0;
    int done_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Decimal model: decode the digits to integers and do plain arithmetic.
    function automatic void model_op(input logic [15:0] a, input logic [15:0] b,
                                     input logic m, input logic c,
                                     output logic [15:0] s, output logic co,
                                     output logic ng, output logic er, output int lat);
        int av, bv, r, p;
        logic [3:0] da, db;
        logic bad;
        av = 0; bv = 0; r = 0; p = 1; bad = 1'b0;
        for (int i = 0; i < N; i++) begin
            da = a[4*i +: 4];
            db = b[4*i +: 4];
            if (da > 4'd9 || db > 4'd9) bad = 1'b1;
            av += int'(da) * p;
            bv += int'(db) * p;
            p  *= 10;
        end
        s = '0; co = 1'b0; ng = 1'b0; er = 1'b0;
        if (bad) begin
            er  = 1'b1;
            lat = 1;
            return;
        end
        if (!m) begin
            r   = av + bv + int'(c);
            co  = (r >= p);
            r   = r % p;
            lat = N + 1;
        end else if (av >= bv) begin
            r   = av - bv;
            lat = N + 1;
        end else begin
            r   = bv - av;
            ng  = 1'b1;
            lat = 2 * N + 1;
        end
        for (int i = 0; i < N; i++) begin
            s[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
    endfunction

    // ---------------- per-cycle compare process ----------------
    logic        busy = 1'b0, acc_pending = 1'b0;
    int          cyc = 0, exp_lat = 0;
    logic [15:0] exp_s = '0, pend_s = '0;
    logic        exp_co = 1'b0, exp_ng = 1'b0, exp_er = 1'b0;
    logic        pend_co = 1'b0, pend_ng = 1'b0, pend_er = 1'b0;
    logic [15:0] cap_a = '0, cap_b = '0;
    logic        cap_m = 1'b0, cap_c = 1'b0;

    always @(negedge clk) begin
        if (bus.done) done_count++;
        if (reset) begin
            busy = 1'b0; acc_pending = 1'b0; cyc = 0;
            exp_s = '0; exp_co = 1'b0; exp_ng = 1'b0; exp_er = 1'b0;
            check("rst_ready", 32'(bus.ready), 32'(1));
            check("rst_done",  32'(bus.done),  32'(0));
            check("rst_S",     32'(bus.S),     32'(0));
            check("rst_cout",  32'(bus.cout),  32'(0));
            check("rst_neg",   32'(bus.neg),   32'(0));
            check("rst_err",   32'(bus.err),   32'(0));
        end else begin
            if (busy) begin
                cyc++;
            end else if (acc_pending) begin
                busy = 1'b1;
                cyc  = 1;
                model_op(cap_a, cap_b, cap_m, cap_c, pend_s, pend_co, pend_ng, pend_er, exp_lat);
            end
            check("ready", 32'(bus.ready), 32'(!busy));
            check("done",  32'(bus.done),  32'(busy && cyc == exp_lat));
            if (busy && cyc == exp_lat) begin
                exp_s = pend_s; exp_co = pend_co; exp_ng = pend_ng; exp_er = pend_er;
            end
            if (!busy || cyc == exp_lat) begin
                check("S",    32'(bus.S),    32'(exp_s));
                check("cout", 32'(bus.cout), 32'(exp_co));
                check("neg",  32'(bus.neg),  32'(exp_ng));
                check("err",  32'(bus.err),  32'(exp_er));
            end
            acc_pending = !busy && bus.start;
            if (acc_pending) begin
                cap_a = bus.A; cap_b = bus.B; cap_m = bus.mode; cap_c = bus.cin;
            end
            if (busy && cyc == exp_lat) busy = 1'b0;
        end
    end

    // ---------------- directed stimulus ----------------
    typedef struct {
        logic [15:0] a, b;
        logic        m, c;
        logic [15:0] s;
        logic        co, ng, er;
        int          lat;
    } vec_t;

    vec_t vecs [11];

    task automatic wait_ready();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #2;
            if (bus.ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("ready_timeout", 32'(bus.ready), 32'(1));
    endtask

    task automatic drive(input vec_t v);
        bus.A = v.a; bus.B = v.b; bus.mode = v.m; bus.cin = v.c;
        bus.start = 1'b1;
    endtask

    // Counts cycles from the accepting edge: the cycle right after it is 1.
    task automatic wait_done(output int k);
        k = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            k++;
            if (bus.done) break;
        end
        if (!bus.done) check("done_timeout", 32'(bus.done), 32'(1));
    endtask

    task automatic check_result(input string tag, input vec_t v, input int k);
        check({tag, "_S"},    32'(bus.S),    32'(v.s));
        check({tag, "_cout"}, 32'(bus.cout), 32'(v.co));
        check({tag, "_neg"},  32'(bus.neg),  32'(v.ng));
        check({tag, "_err"},  32'(bus.err),  32'(v.er));
        check({tag, "_lat"},  32'(k),        32'(v.lat));
        $display("op A=%h B=%h mode=%0d cin=%0d -> S=%h cout=%0d neg=%0d err=%0d latency=%0d",
                 v.a, v.b, v.m, v.c, bus.S, bus.cout, bus.neg, bus.err, k);
    endtask

    task automatic run_vec(input vec_t v);
        int k;
        logic [15:0] ms;
        logic mco, mng, mer;
        int mlat;
        // Pin the model against the hand-computed values.
        model_op(v.a, v.b, v.m, v.c, ms, mco, mng, mer, mlat);
        check("model_S",   32'(ms),   32'(v.s));
        check("model_co",  32'(mco),  32'(v.co));
        check("model_neg", 32'(mng),  32'(v.ng));
        check("model_err", 32'(mer),  32'(v.er));
        check("model_lat", 32'(mlat), 32'(v.lat));
        wait_ready();
        drive(v);
        @(posedge clk); #2;
        bus.start = 1'b0;
        wait_done(k);
        check_result("vec", v, k);
    endtask

    initial begin
        int k;
        int dc0;
        vec_t held;

        vecs[0]  = '{16'h1234, 16'h8766, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 5};
        vecs[1]  = '{16'h5000, 16'h1234, 1'b1, 1'b0, 16'h3766, 1'b0, 1'b0, 1'b0, 5};
        vecs[2]  = '{16'h1234, 16'h5000, 1'b1, 1'b0, 16'h3766, 1'b0, 1'b1, 1'b0, 9};
        vecs[3]  = '{16'h0042, 16'h0042, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 5};
        vecs[4]  = '{16'h12A4, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1};
        vecs[5]  = '{16'h0999, 16'h0001, 1'b0, 1'b1, 16'h1001, 1'b0, 1'b0, 1'b0, 5};
        vecs[6]  = '{16'h9999, 16'h9999, 1'b0, 1'b1, 16'h9999, 1'b1, 1'b0, 1'b0, 5};
        vecs[7]  = '{16'h0000, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b1, 1'b0, 9};
        vecs[8]  = '{16'h0123, 16'h0456, 1'b1, 1'b1, 16'h0333, 1'b0, 1'b1, 1'b0, 9};
        vecs[9]  = '{16'h0100, 16'h00F0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1};
        vecs[10] = '{16'h4321, 16'h1111, 1'b0, 1'b0, 16'h5432, 1'b0, 1'b0, 1'b0, 5};

        bus.start = 1'b0; bus.mode = 1'b0; bus.cin = 1'b0;
        bus.A = '0; bus.B = '0;

        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // start held high through a whole operation: only one is accepted.
        held = '{16'h0042, 16'h0001, 1'b0, 1'b0, 16'h0043, 1'b0, 1'b0, 1'b0, 5};
        wait_ready();
        dc0 = done_count;
        drive(held);
        @(posedge clk); #2;
        wait_done(k);
        check_result("held", held, k);
        @(posedge clk); #2;
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        check("held_done_pulses", 32'(done_count - dc0), 32'(1));

        // Reset in the middle of the NEG pass, then start on the first edge after release.
        wait_ready();
        drive(vecs[2]);
        @(posedge clk); #2;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_ready", 32'(bus.ready), 32'(1));
        check("midrst_S",     32'(bus.S),     32'(0));
        check("midrst_neg",   32'(bus.neg),   32'(0));
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        drive(vecs[10]);
        @(posedge clk); #2;
        bus.start = 1'b0;
        wait_done(k);
        check_result("post_rst", vecs[10], k);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bcd_serial_addsub.md
BCD_SERIAL_ADDSUB -- requirements
Module: bcd_serial_addsub

Interface
REQ-001 SHALL have parameter DIGIT_NUM, default 8, meaning number of BCD digits per operand (legal range 1..16).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request to begin an operation.
REQ-005 SHALL have port mode, input, 1, 0 = add, 1 = subtract (A - B).
REQ-006 SHALL have port cin, input, 1, carry-in, used in add mode only.
REQ-007 SHALL have port A, input, 4*DIGIT_NUM, minuend/augend, packed BCD, LSD at bits [3:0].
REQ-008 SHALL have port B, input, 4*DIGIT_NUM, subtrahend/addend, packed BCD.
REQ-009 SHALL have port ready, output, 1, high only in IDLE.
REQ-010 SHALL have port done, output, 1, one-cycle pulse when the result is valid.
REQ-011 SHALL have port S, output, 4*DIGIT_NUM, result magnitude, packed BCD.
REQ-012 SHALL have port cout, output, 1, decimal carry-out (add overflow); 0 in subtract mode.
REQ-013 SHALL have port neg, output, 1, result sign in subtract mode (1 = A < B); 0 in add mode.
REQ-014 SHALL have port err, output, 1, an operand contained a non-BCD digit (>9).

Function
REQ-015 SHALL accept an operation on the rising edge where start=1 and ready=1, latching A, B, mode and cin; start at any other time is ignored.
REQ-016 SHALL implement states IDLE, ADD, NEG, DONE; transitions: IDLE->ADD on acceptance; ADD->DONE or ADD->NEG after DIGIT_NUM digit cycles; NEG->DONE after DIGIT_NUM digit cycles; DONE->IDLE unconditionally after one cycle.
REQ-017 SHALL check all 2*DIGIT_NUM operand digits at acceptance; if any digit >9, go directly to DONE with S=0, cout=0, neg=0, err=1.
REQ-018 SHALL process one digit per cycle in ADD, LSD first: digit sum = a_i + b_i' + c, with decimal correction (+6 when the binary sum exceeds 9) and carry to the next digit.
REQ-019 SHALL use b_i' = b_i and initial c = cin in add mode; b_i' = 9 - b_i and initial c = 1 in subtract mode (ten's complement).
REQ-020 SHALL, at the end of ADD: add mode -> cout = final carry, neg=0; subtract with final carry 1 -> result positive, neg=0, cout=0, go to DONE; subtract with final carry 0 -> go to NEG.
REQ-021 SHALL in NEG replace each stored result digit d_i, LSD first, with the ten's complement digit (9 - d_i + c), initial c = 1, decimal-corrected; set neg=1, cout=0.
REQ-022 SHALL produce S = 0 with neg=0 for equal operands (no negative zero).
REQ-023 SHALL pulse done high for exactly the DONE cycle; latency from accepting edge to done high: DIGIT_NUM+1 cycles (add, or non-negative subtract), 2*DIGIT_NUM+1 cycles (negative subtract), 1 cycle (err).
REQ-024 SHALL hold S, cout, neg, err stable from done until the edge accepting the next operation.
REQ-025 SHALL keep ready low in ADD, NEG and DONE; earliest re-acceptance is the cycle after done.
REQ-026 SHALL keep a digit counter of width clog2(DIGIT_NUM+1) that wraps to 0 on every state change.

Reset
REQ-027 SHALL on reset (asynchronous, any state, including mid-operation) enter IDLE with ready=1, done=0, S=0, cout=0, neg=0, err=0, counter=0, with shift registers cleared.
REQ-028 SHALL accept a start on the first rising edge after reset deasserts.

Structure
REQ-029 SHALL place the state encoding, the constant 4'd9 and the decimal-correction constant 4'd6 in a shared package bcd_pkg.
REQ-030 SHALL instantiate one sub-module, bcd_digit_adder (4-bit a, 4-bit b, cin -> 4-bit s, cout, combinational), reused in both ADD and NEG.
REQ-031 SHALL hold operands and result in 4*DIGIT_NUM-bit shift registers shifted by 4 bits per digit cycle.

Verification (DIGIT_NUM=4)
REQ-032 SHALL cover add 1234 + 8766, cin=0 -> S=0000, cout=1, neg=0, done 5 cycles after acceptance.
REQ-033 SHALL cover subtract 5000 - 1234 -> S=3766, neg=0, cout=0, latency 5; and 1234 - 5000 -> S=3766, neg=1, latency 9.
REQ-034 SHALL cover subtract 0042 - 0042 -> S=0000, neg=0, latency 5.
REQ-035 SHALL cover A=12A4 -> err=1, S=0000, done 1 cycle after acceptance.
REQ-036 SHALL cover start held high during busy -> exactly one operation accepted; reset asserted mid-NEG -> all outputs at reset values, with a new operation accepted after release.
